uart_rx: RTL

UART receiver that consumes the 16x-oversampling `tick` from the baud-rate generator. It deserialises the asynchronous `rx` line into parallel words and presents each word on a valid/ready output interface. It sits between the baud generator plus the pin and the downstream byte consumer. It reports framing, parity and overrun errors as single-cycle pulses.

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Output side of the UART receiver: received word with valid/ready
// handshake plus the single-cycle error pulses.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling tick. Deserialises rx LSB
// first, optionally checks parity, and hands words out over valid/ready.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick,
    input  logic      rx,
    uart_rx_if.master rxif,
    output logic      busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_m, rx_s;
    logic [3:0]           cnt, cnt_nxt;
    logic [3:0]           idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_nxt;
    logic                 par_fail;
    logic                 deliver;
    logic                 ferr_nxt, perr_nxt;

    // Two-flop synchroniser; idles high like the line itself
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign par_fail = (^shreg) ^ par_bit ^ PARITY_ODD;

    // Next-state logic; everything advances only on tick cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        deliver   = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        cnt_nxt   = '0;
                    end
                end
                START: begin
                    cnt_nxt = cnt + 4'd1;
                    // The detecting tick is tick 0, so the 7th following
                    // tick (count reaching 7) is the start-bit middle.
                    if (cnt == 4'd6) begin
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        cnt_nxt   = '0;
                        idx_nxt   = idx + 4'd1;
                        if (idx == 4'(DATA_BITS - 1))
                            state_nxt = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        par_nxt   = rx_s;
                        cnt_nxt   = '0;
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        cnt_nxt   = '0;
                        perr_nxt  = PARITY_EN && par_fail;
                        ferr_nxt  = !rx_s;
                        deliver   = rx_s && !perr_nxt;
                        state_nxt = rx_s ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_nxt;
        end
    end

    // Output word, handshake and registered error pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxif.rx_data     <= '0;
            rxif.rx_valid    <= 1'b0;
            rxif.frame_err   <= 1'b0;
            rxif.parity_err  <= 1'b0;
            rxif.overrun_err <= 1'b0;
        end else begin
            rxif.frame_err   <= ferr_nxt;
            rxif.parity_err  <= perr_nxt;
            rxif.overrun_err <= deliver && rxif.rx_valid && !rxif.rx_ready;
            if (deliver) begin
                rxif.rx_data  <= shreg;
                rxif.rx_valid <= 1'b1;
            end else if (rxif.rx_valid && rxif.rx_ready) begin
                rxif.rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
